// File: rtl/goertzel_pkg.sv
// Shared types and constants for the sequential Goertzel bin: FSM state encoding,
// counter width helper and Q-format constants.
package goertzel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_X,
        ITER,
        PA,
        PB,
        PC,
        OUT
    } state_e;

    // Sample counter width: max(1, clog2(n)).
    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    localparam int          DW_DEF  = 32;
    localparam int          INT_DEF = 4;
    localparam logic [31:0] ONE     = 32'(1) << (DW_DEF - INT_DEF);

endpackage

// File: rtl/mult_sign.sv
// Signed fixed-point multiplier: Q(INT1_I) x Q(INT2_I) -> Q(INT3_O), truncated and wrapping.
module mult_sign #(
    parameter int DW     = 32,
    parameter int INT1_I = 4,
    parameter int INT2_I = 4,
    parameter int INT3_O = 4
) (
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic [DW-1:0] c_out
);

    // Fraction bits of the full product minus fraction bits of the result.
    localparam int SHIFT = DW - INT1_I - INT2_I + INT3_O;

    logic signed [2*DW-1:0] prod;

    assign prod  = $signed({{DW{a_in[DW-1]}}, a_in}) * $signed({{DW{b_in[DW-1]}}, b_in});
    // Taking the slice at SHIFT is an arithmetic shift (floor) followed by a wrap to DW bits.
    assign c_out = prod[SHIFT +: DW];

endmodule

// File: rtl/goertzel_seq.sv
// One Goertzel bin over N samples, time-sharing a single mult_sign across the
// recurrence and the final power computation.
module goertzel_seq
    import goertzel_pkg::*;
#(
    parameter int DW  = 32,
    parameter int INT = 4,
    parameter int N   = 205
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] coef_in,
    input  logic [DW-1:0] x_in,
    input  logic          x_valid,
    output logic          x_ready,
    output logic [DW-1:0] pwr_out,
    output logic          pwr_valid,
    input  logic          pwr_ready,
    output logic          busy
);

    localparam int            CW       = cnt_w(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [DW-1:0] u_q, u_d, acc_q, acc_d;
    logic [DW-1:0] coef_q, coef_d, x_q, x_d;
    logic [DW-1:0] pwr_q, pwr_d;
    logic          pwr_valid_q, pwr_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [DW-1:0] op_a, op_b, prod;

    // Operand selection depends on state alone so the multiplier path never sees a handshake.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state_q)
            ITER: begin op_a = coef_q; op_b = s1_q; end
            PA:   begin op_a = coef_q; op_b = s2_q; end
            PB:   begin op_a = s1_q;   op_b = u_q;  end
            PC:   begin op_a = s2_q;   op_b = s2_q; end
            default: ;
        endcase
    end

    mult_sign #(
        .DW    (DW),
        .INT1_I(INT),
        .INT2_I(INT),
        .INT3_O(INT)
    ) u_mult (
        .a_in (op_a),
        .b_in (op_b),
        .c_out(prod)
    );

    // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
    always_comb begin
        state_d     = state_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        u_d         = u_q;
        acc_d       = acc_q;
        coef_d      = coef_q;
        x_d         = x_q;
        pwr_d       = pwr_q;
        pwr_valid_d = pwr_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    coef_d  = coef_in;
                    s1_d    = '0;
                    s2_d    = '0;
                    cnt_d   = '0;
                    state_d = WAIT_X;
                end
            end
            WAIT_X: begin
                if (x_valid) begin
                    x_d     = x_in;
                    state_d = ITER;
                end
            end
            ITER: begin
                s1_d = x_q + prod - s2_q;
                s2_d = s1_q;
                if (cnt_q == CNT_LAST) begin
                    state_d = PA;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = WAIT_X;
                end
            end
            PA: begin
                u_d     = s1_q - prod;
                state_d = PB;
            end
            PB: begin
                acc_d   = prod;
                state_d = PC;
            end
            PC: begin
                pwr_d       = acc_q + prod;
                pwr_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (pwr_ready) begin
                    pwr_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            s1_q        <= '0;
            s2_q        <= '0;
            u_q         <= '0;
            acc_q       <= '0;
            coef_q      <= '0;
            x_q         <= '0;
            pwr_q       <= '0;
            pwr_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            u_q         <= u_d;
            acc_q       <= acc_d;
            coef_q      <= coef_d;
            x_q         <= x_d;
            pwr_q       <= pwr_d;
            pwr_valid_q <= pwr_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign x_ready   = (state_q == WAIT_X);
    assign busy      = (state_q != IDLE);
    assign pwr_out   = pwr_q;
    assign pwr_valid = pwr_valid_q;

endmodule
